// File: rtl/mp3_sdi_tx.sv
// mp3_sdi_tx: serialises one byte per accepted md_start onto the MP3 decoder
// SDI pins (DCLK/SDATA/BSYNC) at a programmable bit rate, and synchronises the
// decoder DREQ pin back to the upstream stage.
//
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   md_din[7:0]     - byte to transmit, sampled on accept
//   md_start        - one-cycle strobe, honoured only while md_rdy=1
//   md_rdy          - idle and able to accept a byte
//   md_dreq         - sdi_dreq_pin after a 2-flop synchronizer
//   div[3:0]        - phase length is div+1 clk cycles, sampled on accept
//   sdi_dreq_pin    - raw asynchronous DREQ from the decoder
//   sdi_dclk        - serial clock, decoder samples on the rising edge
//   sdi_data        - serial data
//   sdi_bsync       - byte sync, high through both phases of bit 0
//   busy            - inverse of md_rdy
module mp3_sdi_tx #(
    parameter bit LSB_FIRST = 1'b0,
    parameter bit BSYNC_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] md_din,
    input  logic       md_start,
    output logic       md_rdy,
    output logic       md_dreq,
    input  logic [3:0] div,
    input  logic       sdi_dreq_pin,
    output logic       sdi_dclk,
    output logic       sdi_data,
    output logic       sdi_bsync,
    output logic       busy
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned BW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] sh_q, sh_d;
    logic          rdy_q, rdy_d;
    logic          dclk_q, dclk_d;
    logic          data_q, data_d;
    logic          bsync_q, bsync_d;
    logic          sync1_q, sync2_q;

    // Shift register advanced by one bit towards the output end.
    logic [DW-1:0] sh_next_c;
    assign sh_next_c = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            rdy_q   <= 1'b1;
            dclk_q  <= 1'b0;
            data_q  <= 1'b0;
            bsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            rdy_q   <= rdy_d;
            dclk_q  <= dclk_d;
            data_q  <= data_d;
            bsync_q <= bsync_d;
        end
    end

    // Next-state and next-output logic; outputs are precomputed so that the
    // pins change together with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        rdy_d   = rdy_q;
        dclk_d  = dclk_q;
        data_d  = data_q;
        bsync_d = bsync_q;

        unique case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    state_d = ST_LOW;
                    sh_d    = md_din;
                    div_d   = div;
                    cnt_d   = div;
                    bit_d   = '0;
                    rdy_d   = 1'b0;
                    dclk_d  = 1'b0;
                    data_d  = LSB_FIRST ? md_din[0] : md_din[DW-1];
                    bsync_d = BSYNC_EN;
                end
            end
            ST_LOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_HIGH;
                    cnt_d   = div_q;
                    dclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (bit_q == BW'(DW - 1)) begin
                    // Last bit done: data pin keeps the last bit while idle.
                    state_d = ST_IDLE;
                    rdy_d   = 1'b1;
                    dclk_d  = 1'b0;
                    bsync_d = 1'b0;
                end else begin
                    state_d = ST_LOW;
                    cnt_d   = div_q;
                    bit_d   = bit_q + BW'(1);
                    sh_d    = sh_next_c;
                    dclk_d  = 1'b0;
                    data_d  = LSB_FIRST ? sh_next_c[0] : sh_next_c[DW-1];
                    bsync_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rdy_d   = 1'b1;
                dclk_d  = 1'b0;
                bsync_d = 1'b0;
            end
        endcase
    end

    // Two-flop synchronizer for the asynchronous DREQ pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sdi_dreq_pin;
            sync2_q <= sync1_q;
        end
    end

    assign md_rdy    = rdy_q;
    assign busy      = ~rdy_q;
    assign md_dreq   = sync2_q;
    assign sdi_dclk  = dclk_q;
    assign sdi_data  = data_q;
    assign sdi_bsync = bsync_q;

endmodule
